// File: rtl/uart_tx_serializer_pkg.sv
// uart_tx_serializer_pkg: state encodings and framing constants shared by the UART transmit and receive ends
package uart_tx_serializer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
  localparam int DATA_BITS = 8;
  localparam int DEF_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// baud_tick_gen: bit-period counter giving a one-cycle tick on the last clk of each bit period
// Ports: clk, reset (sync, active-high), clear (hold count at 0), tick (last cycle of the period)
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  assign tick = !clear && cnt == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (reset || clear || tick) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first UART transmitter with a registered, glitch-free serial output
// Ports: clk, reset (sync, active-high), tx_start/tx_data (request and byte, sampled in IDLE),
//        tx_busy (frame in progress), tx_done (last cycle of stop bit), tx (serial line, idle 1)
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);
  state_t state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic tick, tx_n;
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick(tick)
  );
  assign tx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    tx_done = 1'b0;
    case (state)
      IDLE: if (tx_start) begin
        state_n = START;
        shreg_n = tx_data;
        bit_cnt_n = '0;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        shreg_n = shreg >> 1;
        bit_cnt_n = bit_cnt == 3'(DATA_BITS - 1) ? '0 : bit_cnt + 3'd1;
        state_n = bit_cnt == 3'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: begin
        tx_done = tick;
        state_n = tick ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line moves on the same edge as the FSM
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      tx <= tx_n;
    end
endmodule
